// File: rtl/gen_stream_pkg.sv
// Shared types and constants for generator-stream reducers.
// Holds the controller state encoding, the flag bit positions and the most-negative helper.
package gen_stream_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_COLLECT = 3'd2,
    S_EMIT    = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  localparam int FLAG_EMPTY   = 0;
  localparam int FLAG_TIMEOUT = 1;

  // Two's-complement most-negative value for a w-bit signed field (w <= 64).
  function automatic logic [63:0] most_neg(input int unsigned w);
    most_neg = 64'd1 << (w - 32'd1);
  endfunction

endpackage

// File: rtl/gen_stream_reducer_if.sv
// Caller-side and generator-side handshake bundle of the stream reducer.
// The master modport is the reducer; the slave modport is its environment.
interface gen_stream_reducer_if #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 48,
  parameter int CNT_WIDTH = 32
);
  logic                 _start;
  logic [WIDTH-1:0]     n;
  logic                 _ready;
  logic                 _valid;
  logic                 _done;
  logic [ACC_WIDTH-1:0] _out0;
  logic [CNT_WIDTH-1:0] _out1;
  logic [WIDTH-1:0]     _out2;
  logic [1:0]           _out3;

  logic [WIDTH-1:0]     gen_n;
  logic                 gen_start;
  logic                 gen_ready;
  logic                 gen_valid;
  logic                 gen_done;
  logic [WIDTH-1:0]     gen_out0;
  logic [WIDTH-1:0]     gen_out1;

  modport master (
    input  _start, n, _ready, gen_valid, gen_done, gen_out0, gen_out1,
    output _valid, _done, _out0, _out1, _out2, _out3, gen_n, gen_start, gen_ready
  );

  modport slave (
    output _start, n, _ready, gen_valid, gen_done, gen_out0, gen_out1,
    input  _valid, _done, _out0, _out1, _out2, _out3, gen_n, gen_start, gen_ready
  );
endinterface

// File: rtl/gen_stream_reducer_acc.sv
// Reduction datapath: wrapping signed sum, saturating beat count and signed running max.
// Clear has priority over accept; no control state lives here.
module gen_stream_acc
  import gen_stream_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 48,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clear,
  input  logic                 i_accept,
  input  logic [WIDTH-1:0]     i_val0,
  input  logic [WIDTH-1:0]     i_val1,
  output logic [ACC_WIDTH-1:0] o_sum,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic [WIDTH-1:0]     o_max
);
  localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_neg(WIDTH));

  logic [ACC_WIDTH-1:0] r_sum;
  logic [CNT_WIDTH-1:0] r_count;
  logic [WIDTH-1:0]     r_max;
  logic [ACC_WIDTH-1:0] w_val0_ext;

  assign w_val0_ext = {{(ACC_WIDTH - WIDTH){i_val0[WIDTH-1]}}, i_val0};

  // Accumulator registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum   <= '0;
      r_count <= '0;
      r_max   <= '0;
    end else if (i_clear) begin
      r_sum   <= '0;
      r_count <= '0;
      r_max   <= MOST_NEG;
    end else if (i_accept) begin
      r_sum <= r_sum + w_val0_ext;
      if (r_count != {CNT_WIDTH{1'b1}}) begin
        r_count <= r_count + CNT_WIDTH'(1);
      end
      if ($signed(i_val1) > $signed(r_max)) begin
        r_max <= i_val1;
      end
    end
  end

  assign o_sum   = r_sum;
  assign o_count = r_count;
  assign o_max   = r_max;
endmodule

// File: rtl/gen_stream_reducer.sv
// Launches one tuple generator, reduces its stream to (sum, count, max, flags)
// and offers that summary on its own ready/valid/done interface.
module gen_stream_reducer
  import gen_stream_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 48,
  parameter int CNT_WIDTH = 32,
  parameter int TIMEOUT   = 1024,
  parameter int THROTTLE  = 0
) (
  input logic                  _clock,
  input logic                  _reset,
  gen_stream_reducer_if.master bus
);
  localparam int WD_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(TIMEOUT);

  state_t               r_state,     w_state_nxt;
  logic [WIDTH-1:0]     r_gen_n,     w_gen_n_nxt;
  logic                 r_gen_start, w_gen_start_nxt;
  logic                 r_gen_ready, w_gen_ready_nxt;
  logic                 r_valid,     w_valid_nxt;
  logic                 r_done,      w_done_nxt;
  logic                 r_timeout,   w_timeout_nxt;
  logic [ACC_WIDTH-1:0] r_out0,      w_out0_nxt;
  logic [CNT_WIDTH-1:0] r_out1,      w_out1_nxt;
  logic [WIDTH-1:0]     r_out2,      w_out2_nxt;
  logic [1:0]           r_out3,      w_out3_nxt;
  logic [WD_WIDTH-1:0]  r_wd,        w_wd_nxt;
  logic [WD_WIDTH-1:0]  w_wd_inc;
  logic                 w_acc_clear;
  logic                 w_acc_accept;
  logic [ACC_WIDTH-1:0] w_sum;
  logic [CNT_WIDTH-1:0] w_count;
  logic [WIDTH-1:0]     w_max;

  gen_stream_acc #(
    .WIDTH     (WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_acc (
    .i_clk    (_clock),
    .i_rst_n  (_reset),
    .i_clear  (w_acc_clear),
    .i_accept (w_acc_accept),
    .i_val0   (bus.gen_out0),
    .i_val1   (bus.gen_out1),
    .o_sum    (w_sum),
    .o_count  (w_count),
    .o_max    (w_max)
  );

  assign w_wd_inc = r_wd + WD_WIDTH'(1);

  // Next-state and next-output logic; _start overrides every state.
  always_comb begin
    w_state_nxt     = r_state;
    w_gen_n_nxt     = r_gen_n;
    w_gen_start_nxt = r_gen_start;
    w_gen_ready_nxt = r_gen_ready;
    w_valid_nxt     = r_valid;
    w_done_nxt      = 1'b0;
    w_timeout_nxt   = r_timeout;
    w_out0_nxt      = r_out0;
    w_out1_nxt      = r_out1;
    w_out2_nxt      = r_out2;
    w_out3_nxt      = r_out3;
    w_wd_nxt        = r_wd;
    w_acc_clear     = 1'b0;
    w_acc_accept    = 1'b0;

    if (bus._start) begin
      w_gen_n_nxt     = bus.n;
      w_gen_start_nxt = 1'b1;
      w_gen_ready_nxt = 1'b0;
      w_valid_nxt     = 1'b0;
      w_timeout_nxt   = 1'b0;
      w_wd_nxt        = '0;
      w_acc_clear     = 1'b1;
      w_state_nxt     = S_LAUNCH;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_IDLE;
        end
        S_LAUNCH: begin
          w_gen_start_nxt = 1'b0;
          w_gen_ready_nxt = 1'b1;
          w_state_nxt     = S_COLLECT;
        end
        S_COLLECT: begin
          w_acc_accept = bus.gen_valid && r_gen_ready;
          if (w_acc_accept) begin
            w_wd_nxt = '0;
          end else if (!bus.gen_valid && !bus.gen_done) begin
            w_wd_nxt = w_wd_inc;
          end else begin
            w_wd_nxt = r_wd;
          end
          // Silence-based abort only counts cycles where the generator shows nothing.
          if (bus.gen_done) begin
            w_gen_ready_nxt = 1'b0;
            w_state_nxt     = S_EMIT;
          end else if ((TIMEOUT != 0) && !bus.gen_valid && (w_wd_inc == WD_LIMIT)) begin
            w_gen_ready_nxt = 1'b0;
            w_timeout_nxt   = 1'b1;
            w_state_nxt     = S_EMIT;
          end else if (THROTTLE != 0) begin
            w_gen_ready_nxt = ~r_gen_ready;
          end else begin
            w_gen_ready_nxt = r_gen_ready;
          end
        end
        S_EMIT: begin
          if (!r_valid) begin
            w_out0_nxt                = w_sum;
            w_out1_nxt                = w_count;
            w_out2_nxt                = w_max;
            w_out3_nxt                = 2'b00;
            w_out3_nxt[FLAG_EMPTY]    = (w_count == '0);
            w_out3_nxt[FLAG_TIMEOUT]  = r_timeout;
            w_valid_nxt               = 1'b1;
          end else if (bus._ready) begin
            w_valid_nxt = 1'b0;
            w_state_nxt = S_FINISH;
          end else begin
            w_valid_nxt = 1'b1;
          end
        end
        S_FINISH: begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      r_state     <= S_IDLE;
      r_gen_n     <= '0;
      r_gen_start <= 1'b0;
      r_gen_ready <= 1'b0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_out0      <= '0;
      r_out1      <= '0;
      r_out2      <= '0;
      r_out3      <= 2'b00;
      r_wd        <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gen_n     <= w_gen_n_nxt;
      r_gen_start <= w_gen_start_nxt;
      r_gen_ready <= w_gen_ready_nxt;
      r_valid     <= w_valid_nxt;
      r_done      <= w_done_nxt;
      r_timeout   <= w_timeout_nxt;
      r_out0      <= w_out0_nxt;
      r_out1      <= w_out1_nxt;
      r_out2      <= w_out2_nxt;
      r_out3      <= w_out3_nxt;
      r_wd        <= w_wd_nxt;
    end
  end

  assign bus.gen_n     = r_gen_n;
  assign bus.gen_start = r_gen_start;
  assign bus.gen_ready = r_gen_ready;
  assign bus._valid    = r_valid;
  assign bus._done     = r_done;
  assign bus._out0     = r_out0;
  assign bus._out1     = r_out1;
  assign bus._out2     = r_out2;
  assign bus._out3     = r_out3;
endmodule

// File: tb/tb_gen_stream_reducer.sv
// Bench for gen_stream_reducer: an hrange-style tuple stub feeds one of two DUTs
// (plain and throttled); expected summaries are queued at launch and popped on handshake.
module tb_gen_stream_reducer;

  typedef struct packed {
    logic [47:0] o0;
    logic [31:0] o1;
    logic [31:0] o2;
    logic [1:0]  o3;
  } exp_t;

  logic clk;
  logic rst_n;
  logic sel;
  logic stub_mute;
  int   n_vec;
  int   n_err;
  exp_t sb_q[$];

  gen_stream_reducer_if #(.WIDTH(32), .ACC_WIDTH(48), .CNT_WIDTH(32)) bus_a ();
  gen_stream_reducer_if #(.WIDTH(32), .ACC_WIDTH(48), .CNT_WIDTH(32)) bus_b ();

  gen_stream_reducer #(
    .WIDTH(32), .ACC_WIDTH(48), .CNT_WIDTH(32), .TIMEOUT(16), .THROTTLE(0)
  ) dut_a (
    ._clock (clk),
    ._reset (rst_n),
    .bus    (bus_a)
  );

  gen_stream_reducer #(
    .WIDTH(32), .ACC_WIDTH(48), .CNT_WIDTH(32), .TIMEOUT(16), .THROTTLE(1)
  ) dut_b (
    ._clock (clk),
    ._reset (rst_n),
    .bus    (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generator stub: emits (i, i) for i = 0..n-1, each held until accepted, then done.
  logic        st_start;
  logic        st_ready;
  logic [31:0] st_n;
  logic        stub_act;
  logic [31:0] stub_i;
  logic [31:0] stub_n;
  logic        stub_valid;
  logic        stub_done;

  assign st_start   = sel ? bus_b.gen_start : bus_a.gen_start;
  assign st_ready   = sel ? bus_b.gen_ready : bus_a.gen_ready;
  assign st_n       = sel ? bus_b.gen_n     : bus_a.gen_n;
  assign stub_valid = stub_act && (stub_i < stub_n);
  assign stub_done  = stub_act && (stub_i == stub_n);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_act <= 1'b0;
      stub_i   <= 32'd0;
      stub_n   <= 32'd0;
    end else if (st_start) begin
      stub_act <= !stub_mute;
      stub_i   <= 32'd0;
      stub_n   <= st_n;
    end else if (stub_act) begin
      if (stub_done) stub_act <= 1'b0;
      else if (stub_valid && st_ready) stub_i <= stub_i + 32'd1;
    end
  end

  assign bus_a.gen_valid = !sel && stub_valid;
  assign bus_b.gen_valid =  sel && stub_valid;
  assign bus_a.gen_done  = !sel && stub_done;
  assign bus_b.gen_done  =  sel && stub_done;
  assign bus_a.gen_out0  = stub_i;
  assign bus_a.gen_out1  = stub_i;
  assign bus_b.gen_out0  = stub_i;
  assign bus_b.gen_out1  = stub_i;

  logic        cur_valid;
  logic        cur_ready;
  logic        cur_done;
  logic [47:0] cur_out0;
  logic [31:0] cur_out1;
  logic [31:0] cur_out2;
  logic [1:0]  cur_out3;

  assign cur_valid = sel ? bus_b._valid : bus_a._valid;
  assign cur_ready = sel ? bus_b._ready : bus_a._ready;
  assign cur_done  = sel ? bus_b._done  : bus_a._done;
  assign cur_out0  = sel ? bus_b._out0  : bus_a._out0;
  assign cur_out1  = sel ? bus_b._out1  : bus_a._out1;
  assign cur_out2  = sel ? bus_b._out2  : bus_a._out2;
  assign cur_out3  = sel ? bus_b._out3  : bus_a._out3;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input int n, input bit tmo);
    exp_t r;
    r.o0 = 48'd0;
    r.o1 = 32'd0;
    r.o2 = 32'h8000_0000;
    if (!tmo) begin
      for (int i = 0; i < n; i++) begin
        r.o0 = r.o0 + 48'(i);
        r.o1 = r.o1 + 32'd1;
        if (i > $signed(r.o2)) r.o2 = 32'(i);
      end
    end
    r.o3 = {tmo, (r.o1 == 32'd0)};
    return r;
  endfunction

  // Scoreboard: compare the presented summary whenever a handshake is about to occur.
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (rst_n && cur_valid && cur_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_depth", 64'(sb_q.size()), 64'd1);
      end else begin
        e = sb_q.pop_front();
        check_eq("out0", 64'(cur_out0), 64'(e.o0));
        check_eq("out1", 64'(cur_out1), 64'(e.o1));
        check_eq("out2", 64'(cur_out2), 64'(e.o2));
        check_eq("out3", 64'(cur_out3), 64'(e.o3));
      end
    end
  end

  task automatic set_ready(input logic v);
    if (sel) bus_b._ready = v;
    else     bus_a._ready = v;
  endtask

  task automatic start_gen(input int n, input bit tmo, input bit push);
    if (push) sb_q.push_back(model(n, tmo));
    if (sel) begin bus_b.n = 32'(n); bus_b._start = 1'b1; end
    else     begin bus_a.n = 32'(n); bus_a._start = 1'b1; end
    @(negedge clk);
    bus_a._start = 1'b0;
    bus_b._start = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!cur_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("valid_rise", 64'(cur_valid), 64'd1);
  endtask

  // Called at the negedge just before the handshake edge.
  task automatic check_done_pulse();
    @(negedge clk);
    check_eq("valid_drop", 64'(cur_valid), 64'd0);
    check_eq("done_early", 64'(cur_done), 64'd0);
    @(negedge clk);
    check_eq("done_pulse", 64'(cur_done), 64'd1);
    @(negedge clk);
    check_eq("done_clear", 64'(cur_done), 64'd0);
  endtask

  task automatic check_reset_vals();
    check_eq("rst_valid", 64'(bus_a._valid),    64'd0);
    check_eq("rst_done",  64'(bus_a._done),     64'd0);
    check_eq("rst_gstart",64'(bus_a.gen_start), 64'd0);
    check_eq("rst_gready",64'(bus_a.gen_ready), 64'd0);
    check_eq("rst_gen_n", 64'(bus_a.gen_n),     64'd0);
    check_eq("rst_out0",  64'(bus_a._out0),     64'd0);
    check_eq("rst_out1",  64'(bus_a._out1),     64'd0);
    check_eq("rst_out2",  64'(bus_a._out2),     64'd0);
    check_eq("rst_out3",  64'(bus_a._out3),     64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    sel = 1'b0;
    stub_mute = 1'b0;
    bus_a._start = 1'b0; bus_a.n = 32'd0; bus_a._ready = 1'b0;
    bus_b._start = 1'b0; bus_b.n = 32'd0; bus_b._ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);

    // n=10 with the caller always ready.
    set_ready(1'b1);
    start_gen(10, 1'b0, 1'b1);
    check_eq("gen_n", 64'(bus_a.gen_n), 64'd10);
    wait_valid(c);
    check_done_pulse();

    // Empty stream and minimum latency.
    start_gen(0, 1'b0, 1'b1);
    wait_valid(c);
    check_eq("lat_empty", 64'(c), 64'd3);
    check_done_pulse();

    // Throttled ready on the second instance.
    sel = 1'b1;
    set_ready(1'b1);
    start_gen(4, 1'b0, 1'b1);
    wait_valid(c);
    check_done_pulse();
    sel = 1'b0;

    // Caller back-pressure: result must stay put for six cycles.
    set_ready(1'b0);
    start_gen(5, 1'b0, 1'b1);
    wait_valid(c);
    for (int i = 0; i < 6; i++) begin
      check_eq("hold_valid", 64'(cur_valid), 64'd1);
      check_eq("hold_out0",  64'(cur_out0),  64'd10);
      check_eq("hold_done",  64'(cur_done),  64'd0);
      @(negedge clk);
    end
    set_ready(1'b1);
    check_done_pulse();

    // Silent generator: watchdog abort.
    stub_mute = 1'b1;
    start_gen(7, 1'b1, 1'b1);
    wait_valid(c);
    check_eq("lat_timeout", 64'(c), 64'd18);
    check_done_pulse();
    stub_mute = 1'b0;

    // Reset in the middle of collection, then a fresh run.
    start_gen(10, 1'b0, 1'b0);
    c = 0;
    while (stub_i != 32'd3 && c < 20) begin
      @(negedge clk);
      c++;
    end
    check_eq("beats_before_rst", 64'(stub_i), 64'd3);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);
    start_gen(2, 1'b0, 1'b1);
    wait_valid(c);
    check_done_pulse();

    check_eq("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
